// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types, default latency/streak limits and streak counter width helper
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_READ, ARB_WRITE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  localparam int ARB_RD_LAT = 2;
  localparam int ARB_MAX_DSTREAK = 2;
  function automatic int streak_w(input int max_streak);
    return $clog2(max_streak + 2);
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-first winner select (in: if_req, d_req, dstreak; out: owner, valid), fetch wins once the data streak hits its cap
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int MAX_DSTREAK = ARB_MAX_DSTREAK,
  localparam int SW = streak_w(MAX_DSTREAK)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] dstreak,
  output arb_owner_t    owner,
  output logic          valid
);
  always_comb begin
    valid = if_req | d_req;
    owner = (d_req && !(if_req && dstreak == SW'(MAX_DSTREAK))) ? OWN_D : OWN_IF;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch (if_*) and data (d_*) requesters, driving mem_* and returning registered rdata/rvalid
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = ARB_RD_LAT,
  parameter int MAX_DSTREAK = ARB_MAX_DSTREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = streak_w(MAX_DSTREAK);
  localparam int LW = $clog2(RD_LAT + 1);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d, pick_own;
  logic pick_vld, idle, grant, take_d, done;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;

  mem_arb_pick #(.MAX_DSTREAK(MAX_DSTREAK)) u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .dstreak (dstreak_q),
    .owner   (pick_own),
    .valid   (pick_vld)
  );

  assign idle   = state_q == ARB_IDLE;
  assign grant  = idle && pick_vld;
  assign take_d = grant && pick_own == OWN_D;
  assign done   = state_q == ARB_READ && lat_q == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      dstreak_q   <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      dstreak_q   <= dstreak_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb
    state_d = grant ? ((take_d && d_we) ? ARB_WRITE : ARB_READ)
            : (state_q == ARB_WRITE || done) ? ARB_IDLE : state_q;

  always_comb begin
    owner_d     = grant ? pick_own : owner_q;
    if_gnt_d    = grant && !take_d;
    d_gnt_d     = take_d;
    if_rvalid_d = done && owner_q == OWN_IF;
    d_rvalid_d  = done && owner_q == OWN_D;
    mem_addr_d  = grant ? (take_d ? d_addr : if_addr) : mem_addr_q;
    mem_wdata_d = take_d ? d_wdata : mem_wdata_q;
    mem_wr_d    = take_d && d_we;
    lat_d       = grant ? LW'(RD_LAT - 1) : (state_q == ARB_READ && !done) ? lat_q - 1'b1 : lat_q;
    rdata_d     = done ? mem_rdata : rdata_q;
    dstreak_d   = !idle ? dstreak_q
                : (!if_req || !take_d) ? '0
                : (dstreak_q == SW'(MAX_DSTREAK)) ? dstreak_q : dstreak_q + 1'b1;
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign busy      = state_q != ARB_IDLE;
endmodule
